galaga_rom_loader: RTL and testbench

// Sequences the HPS ROM download into the Galaga core. Decodes each ioctl byte

---
 rtl/galaga_rom_loader_if.sv | 29 ++
 rtl/galaga_rom_loader.sv | 149 ++++++++++++++
 tb/tb_galaga_rom_loader.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/galaga_rom_loader_if.sv
`default_nettype none
// ============================================================================
// galaga_rom_loader_if : HPS download bus in, per-region ROM write bus out
// Revision 1.0
// ============================================================================
interface galaga_rom_loader_if;
  logic        dn_download;
  logic        dn_wr;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic [5:0]  rom_we;
  logic        core_reset;
  logic        load_done;
  logic        load_error;
  logic [16:0] byte_count;

  modport master (
    output dn_download, dn_wr, dn_addr, dn_data,
    input  rom_addr, rom_data, rom_we, core_reset, load_done, load_error, byte_count
  );

  modport slave (
    input  dn_download, dn_wr, dn_addr, dn_data,
    output rom_addr, rom_data, rom_we, core_reset, load_done, load_error, byte_count
  );
endinterface
`default_nettype wire

// File: rtl/galaga_rom_loader.sv
`default_nettype none
// ============================================================================
// galaga_rom_loader : routes the HPS ROM image into six regions, gates core reset
// Revision 1.0
// ============================================================================
module galaga_rom_loader #(
  parameter logic [16:0] END0        = 17'h04000,
  parameter logic [16:0] END1        = 17'h05000,
  parameter logic [16:0] END2        = 17'h06000,
  parameter logic [16:0] END3        = 17'h07000,
  parameter logic [16:0] END4        = 17'h09000,
  parameter logic [16:0] TOTAL_LEN   = 17'h09400,
  parameter int          HOLD_CYCLES = 16
) (
  input logic                 clk_sys,
  input logic                 reset,
  galaga_rom_loader_if.slave  bus
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]  C_HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [16:0]    C_COUNT_MAX = 17'h1FFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_HOLD  = 3'd2,
    S_RUN   = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t        r_state, w_state_next;
  logic          r_dl_q;
  logic          r_ovf, w_ovf_next;
  logic [HW-1:0] r_hold, w_hold_next;
  logic [16:0]   r_count, w_count_next;
  logic [5:0]    r_rom_we;
  logic [15:0]   r_rom_addr;
  logic [7:0]    r_rom_data;
  logic          r_core_reset, r_load_done, r_load_error;

  logic          w_rise, w_fall, w_in_range, w_accept, w_drop;
  logic [5:0]    w_sel;
  logic [15:0]   w_base;
  logic [16:0]   w_count_inc;

  assign w_rise     = bus.dn_download & ~r_dl_q;
  assign w_fall     = ~bus.dn_download & r_dl_q;
  assign w_in_range = bus.dn_addr < TOTAL_LEN;
  assign w_accept   = (r_state == S_LOAD) & bus.dn_wr & w_in_range;
  assign w_drop     = (r_state == S_LOAD) & bus.dn_wr & ~w_in_range;
  assign w_count_inc = (w_accept && r_count != C_COUNT_MAX) ? r_count + 17'd1 : r_count;

  // Every region is below 64 KiB, so the 16-bit difference is exact.
  always_comb begin
    w_sel  = '0;
    w_base = '0;
    if (bus.dn_addr < END0) begin
      w_sel[0] = 1'b1;
    end else if (bus.dn_addr < END1) begin
      w_sel[1] = 1'b1;
      w_base   = END0[15:0];
    end else if (bus.dn_addr < END2) begin
      w_sel[2] = 1'b1;
      w_base   = END1[15:0];
    end else if (bus.dn_addr < END3) begin
      w_sel[3] = 1'b1;
      w_base   = END2[15:0];
    end else if (bus.dn_addr < END4) begin
      w_sel[4] = 1'b1;
      w_base   = END3[15:0];
    end else if (w_in_range) begin
      w_sel[5] = 1'b1;
      w_base   = END4[15:0];
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold;
    w_count_next = r_count;
    w_ovf_next   = r_ovf;
    case (r_state)
      S_LOAD: begin
        // A write coinciding with the download fall still counts toward the image.
        w_count_next = w_count_inc;
        w_ovf_next   = r_ovf | w_drop;
        if (w_fall) begin
          w_hold_next  = '0;
          w_state_next = (w_count_inc == TOTAL_LEN && !w_ovf_next) ? S_HOLD : S_ERROR;
        end
      end
      S_HOLD: begin
        if (r_hold == C_HOLD_LAST) w_state_next = S_RUN;
        else                       w_hold_next  = r_hold + 1'b1;
      end
      default: begin
        if (w_rise) begin
          w_state_next = S_LOAD;
          w_count_next = '0;
          w_ovf_next   = 1'b0;
          w_hold_next  = '0;
        end
      end
    endcase
  end

  // The download delay register keeps sampling through reset so a download
  // still high when reset releases is not mistaken for a new one.
  always_ff @(posedge clk_sys) r_dl_q <= bus.dn_download;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_hold       <= '0;
      r_count      <= '0;
      r_ovf        <= 1'b0;
      r_rom_we     <= '0;
      r_rom_addr   <= '0;
      r_rom_data   <= '0;
      r_core_reset <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_hold       <= w_hold_next;
      r_count      <= w_count_next;
      r_ovf        <= w_ovf_next;
      r_rom_we     <= w_accept ? w_sel : 6'b0;
      if (w_accept) begin
        r_rom_addr <= bus.dn_addr[15:0] - w_base;
        r_rom_data <= bus.dn_data;
      end
      r_core_reset <= (w_state_next != S_RUN);
      r_load_done  <= (w_state_next == S_RUN);
      r_load_error <= (w_state_next == S_ERROR);
    end
  end

  assign bus.rom_we     = r_rom_we;
  assign bus.rom_addr   = r_rom_addr;
  assign bus.rom_data   = r_rom_data;
  assign bus.core_reset = r_core_reset;
  assign bus.load_done  = r_load_done;
  assign bus.load_error = r_load_error;
  assign bus.byte_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_galaga_rom_loader.sv
`default_nettype none
// ============================================================================
// tb_galaga_rom_loader : directed vectors and load sequences for the ROM loader
// Revision 1.0
// ============================================================================
module tb_galaga_rom_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dl = 1'b0;
  logic        wr = 1'b0;
  logic [16:0] addr = '0;
  logic [7:0]  data = '0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  galaga_rom_loader_if bus ();
  galaga_rom_loader_if bus_s ();

  assign bus.dn_download   = dl;
  assign bus.dn_wr         = wr;
  assign bus.dn_addr       = addr;
  assign bus.dn_data       = data;
  assign bus_s.dn_download = dl;
  assign bus_s.dn_wr       = wr;
  assign bus_s.dn_addr     = addr;
  assign bus_s.dn_data     = data;

  galaga_rom_loader u_dut (
    .clk_sys (clk),
    .reset   (rst),
    .bus     (bus.slave)
  );

  // Scaled-down image so the over-length case stays short.
  galaga_rom_loader #(
    .END0(17'h00040), .END1(17'h00050), .END2(17'h00060), .END3(17'h00070),
    .END4(17'h00090), .TOTAL_LEN(17'h00094), .HOLD_CYCLES(4)
  ) u_small (
    .clk_sys (clk),
    .reset   (rst),
    .bus     (bus_s.slave)
  );

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  data;
    logic [5:0]  we;
    logic [15:0] raddr;
  } vec_t;

  vec_t vecs [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    int cnt [6];
    int bad_onehot;
    int first_low;
    int reset_drops;
    logic [16:0] snap;

    vecs[0]  = '{17'h00000, 8'h11, 6'b000001, 16'h0000};
    vecs[1]  = '{17'h03FFF, 8'h22, 6'b000001, 16'h3FFF};
    vecs[2]  = '{17'h04000, 8'h33, 6'b000010, 16'h0000};
    vecs[3]  = '{17'h04FFF, 8'h44, 6'b000010, 16'h0FFF};
    vecs[4]  = '{17'h05010, 8'hA5, 6'b000100, 16'h0010};
    vecs[5]  = '{17'h05FFF, 8'h55, 6'b000100, 16'h0FFF};
    vecs[6]  = '{17'h06000, 8'h66, 6'b001000, 16'h0000};
    vecs[7]  = '{17'h06FFF, 8'h77, 6'b001000, 16'h0FFF};
    vecs[8]  = '{17'h07000, 8'h88, 6'b010000, 16'h0000};
    vecs[9]  = '{17'h08FFF, 8'h99, 6'b010000, 16'h1FFF};
    vecs[10] = '{17'h09000, 8'hAA, 6'b100000, 16'h0000};
    vecs[11] = '{17'h093FF, 8'hBB, 6'b100000, 16'h03FF};
    vecs[12] = '{17'h09400, 8'hCC, 6'b000000, 16'h0000};
    vecs[13] = '{17'h1FFFF, 8'hDD, 6'b000000, 16'h0000};

    // Reset state
    tick(); tick();
    chk("rst_rom_we", 32'(bus.rom_we), 32'h0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
    chk("rst_rom_data", 32'(bus.rom_data), 32'h0);
    chk("rst_core_reset", 32'(bus.core_reset), 32'h1);
    chk("rst_load_done", 32'(bus.load_done), 32'h0);
    chk("rst_load_error", 32'(bus.load_error), 32'h0);
    chk("rst_byte_count", 32'(bus.byte_count), 32'h0);
    rst = 1'b0;
    tick();

    // Reset in the middle of a load
    dl = 1'b1; tick();
    for (int a = 0; a < 'h100; a++) begin
      addr = 17'(a); data = 8'(a); wr = 1'b1; tick();
    end
    chk("mid_count", 32'(bus.byte_count), 32'h100);
    rst = 1'b1; tick();
    chk("midrst_rom_we", 32'(bus.rom_we), 32'h0);
    chk("midrst_count", 32'(bus.byte_count), 32'h0);
    chk("midrst_core_reset", 32'(bus.core_reset), 32'h1);
    wr = 1'b0; dl = 1'b0; tick();
    rst = 1'b0; tick();
    chk("midrst_load_done", 32'(bus.load_done), 32'h0);

    // Full sequential image; final write coincides with the download fall
    for (int b = 0; b < 6; b++) cnt[b] = 0;
    bad_onehot = 0;
    dl = 1'b1; tick();
    for (int a = 0; a < 'h9400; a++) begin
      addr = 17'(a); data = 8'(a); wr = 1'b1;
      if (a == 'h93FF) dl = 1'b0;
      tick();
      if ($countones(bus.rom_we) != 1) bad_onehot++;
      for (int b = 0; b < 6; b++) if (bus.rom_we[b]) cnt[b]++;
    end
    wr = 1'b0;
    chk("full_onehot_errs", 32'(bad_onehot), 32'h0);
    chk("full_we0", 32'(cnt[0]), 32'h4000);
    chk("full_we1", 32'(cnt[1]), 32'h1000);
    chk("full_we2", 32'(cnt[2]), 32'h1000);
    chk("full_we3", 32'(cnt[3]), 32'h1000);
    chk("full_we4", 32'(cnt[4]), 32'h2000);
    chk("full_we5", 32'(cnt[5]), 32'h0400);
    chk("full_count", 32'(bus.byte_count), 32'h9400);
    chk("hold_entry_core_reset", 32'(bus.core_reset), 32'h1);
    first_low = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (!bus.core_reset && first_low == 0) first_low = k;
    end
    chk("hold_cycles", 32'(first_low), 32'd16);
    chk("run_load_done", 32'(bus.load_done), 32'h1);
    chk("run_load_error", 32'(bus.load_error), 32'h0);

    // Writes while running are ignored
    snap = bus.byte_count;
    bad_onehot = 0;
    for (int a = 0; a < 3; a++) begin
      addr = 17'(a * 'h10); data = 8'hEE; wr = 1'b1; tick();
      if (bus.rom_we != 6'b0) bad_onehot++;
    end
    wr = 1'b0; tick();
    chk("run_wr_rom_we", 32'(bad_onehot), 32'h0);
    chk("run_wr_count", 32'(bus.byte_count), 32'(snap));
    chk("run_wr_core_reset", 32'(bus.core_reset), 32'h0);

    // Region decode boundaries, one write per vector
    dl = 1'b1; tick();
    for (int i = 0; i < 14; i++) begin
      addr = vecs[i].addr; data = vecs[i].data; wr = 1'b1;
      tick();
      chk($sformatf("vec%0d_we", i), 32'(bus.rom_we), 32'(vecs[i].we));
      if (vecs[i].we != 6'b0) begin
        chk($sformatf("vec%0d_addr", i), 32'(bus.rom_addr), 32'(vecs[i].raddr));
        chk($sformatf("vec%0d_data", i), 32'(bus.rom_data), 32'(vecs[i].data));
      end
    end
    wr = 1'b0; tick();
    chk("vec_we_pulse", 32'(bus.rom_we), 32'h0);
    chk("vec_count", 32'(bus.byte_count), 32'd12);
    chk("vec_load_done_cleared", 32'(bus.load_done), 32'h0);
    dl = 1'b0; tick(); tick();
    chk("vec_load_error", 32'(bus.load_error), 32'h1);

    // Short image by one byte
    dl = 1'b1; tick();
    chk("reload_error_cleared", 32'(bus.load_error), 32'h0);
    for (int a = 0; a < 'h93FF; a++) begin
      addr = 17'(a); data = 8'(a); wr = 1'b1; tick();
    end
    wr = 1'b0; dl = 1'b0; tick(); tick();
    chk("short_load_error", 32'(bus.load_error), 32'h1);
    chk("short_count", 32'(bus.byte_count), 32'h093FF);
    chk("short_load_done", 32'(bus.load_done), 32'h0);
    reset_drops = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (!bus.core_reset) reset_drops++;
    end
    chk("short_core_reset_held", 32'(reset_drops), 32'h0);

    // Full scaled image plus one write at the end address
    dl = 1'b1; tick();
    for (int a = 0; a < 'h94; a++) begin
      addr = 17'(a); data = 8'(a); wr = 1'b1; tick();
    end
    addr = 17'h00094; data = 8'h5A; tick();
    chk("long_extra_rom_we", 32'(bus_s.rom_we), 32'h0);
    chk("long_count", 32'(bus_s.byte_count), 32'h94);
    wr = 1'b0; dl = 1'b0; tick(); tick();
    chk("long_load_error", 32'(bus_s.load_error), 32'h1);
    chk("long_core_reset", 32'(bus_s.core_reset), 32'h1);
    for (int k = 0; k < 8; k++) tick();
    chk("long_load_done", 32'(bus_s.load_done), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
